// File: rtl/iob_bus_arbiter2.sv
// iob_bus_arbiter2: two-requester (instruction/data) arbiter onto a single memory port.
// One transaction in flight; ties in IDLE go to the requester not served last.
module iob_bus_arbiter2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_wstrb_q, m_wstrb_d;
  logic grant_d, grant_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end
  // data wins a tie unless it was the last one served
  assign grant_d = d_valid && (!i_valid || !last_d_q);
  assign grant_i = i_valid && !grant_d;
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    if (state_q == IDLE) begin
      if (grant_d) begin
        state_d   = BUSY_D;
        last_d_d  = 1'b1;
        m_addr_d  = d_addr;
        m_wdata_d = d_wdata;
        m_wstrb_d = d_wstrb;
      end else if (grant_i) begin
        state_d   = BUSY_I;
        last_d_d  = 1'b0;
        m_addr_d  = i_addr;
        m_wdata_d = '0;
        m_wstrb_d = '0;
      end
    end else if (m_ready) begin
      state_d = IDLE;
    end
  end
  assign m_valid = state_q != IDLE;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign i_ready = (state_q == BUSY_I) && m_ready;
  assign d_ready = (state_q == BUSY_D) && m_ready;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
endmodule

// File: tb/tb_iob_bus_arbiter2.sv
// tb_iob_bus_arbiter2: directed scenarios plus a randomized run against a transaction-level model.
module tb_iob_bus_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  logic clk = 1'b0, rst = 1'b1;
  logic i_valid = 1'b0, d_valid = 1'b0, m_ready = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, m_rdata = '0;
  logic [SW-1:0] d_wstrb = '0;
  logic i_ready, d_ready, m_valid;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_wstrb;
  int checks = 0, failures = 0;
  // model: who owns the bus (0 none, 1 instr, 2 data), who was served last, latched request
  int own;
  bit mlast;
  logic [AW-1:0] ea;
  logic [DW-1:0] ew;
  logic [SW-1:0] es;

  iob_bus_arbiter2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic void model_edge();
    if (own == 0) begin
      if (d_valid && (!i_valid || !mlast)) begin
        own = 2; mlast = 1'b1; ea = d_addr; ew = d_wdata; es = d_wstrb;
      end else if (i_valid) begin
        own = 1; mlast = 1'b0; ea = i_addr; ew = '0; es = '0;
      end
    end else if (m_ready) own = 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    own = 0; mlast = 1'b0; ea = '0; ew = '0; es = '0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 checks++;
    if ({m_valid, i_ready, d_ready, m_addr, m_wdata, m_wstrb} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {m_valid, i_ready, d_ready, m_addr, m_wdata, m_wstrb});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 checks++;
    if ({m_valid, i_ready, d_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release got=%b exp=000", {m_valid, i_ready, d_ready});
    end
  endtask

  task automatic test_instr();
    logic [DW-1:0] rd;
    do_reset();
    i_valid = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL instr_pre_grant m_valid=%b exp=0", m_valid); end
    @(posedge clk);
    #1 checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 32'h100, 32'h0, 4'h0}) begin
      failures++;
      $display("FAIL instr_grant got=%b/%h/%h/%h exp=1/100/0/0", m_valid, m_addr, m_wdata, m_wstrb);
    end
    @(posedge clk);
    #1 checks++;
    if ({m_valid, i_ready, d_ready, m_addr} !== {3'b100, 32'h100}) begin
      failures++;
      $display("FAIL instr_hold got=%b%b%b/%h exp=100/100", m_valid, i_ready, d_ready, m_addr);
    end
    rd = $urandom; m_ready = 1'b1; m_rdata = rd;
    #1 checks++;
    if ({i_ready, d_ready, i_rdata} !== {2'b10, rd}) begin
      failures++;
      $display("FAIL instr_resp got=%b%b/%h exp=10/%h", i_ready, d_ready, i_rdata, rd);
    end
    @(posedge clk);
    #1 i_valid = 1'b0; m_ready = 1'b0;
    checks++;
    if ({m_valid, i_ready, d_ready} !== 3'b000) begin
      failures++;
      $display("FAIL instr_done got=%b exp=000", {m_valid, i_ready, d_ready});
    end
  endtask

  task automatic test_data();
    logic [DW-1:0] rd;
    int pulses = 0;
    do_reset();
    d_valid = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    @(posedge clk);
    #1 checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 32'h2004, 32'hDEADBEEF, 4'hF}) begin
      failures++;
      $display("FAIL data_grant got=%b/%h/%h/%h exp=1/2004/deadbeef/f", m_valid, m_addr, m_wdata, m_wstrb);
    end
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      if (d_ready) pulses++;
      @(posedge clk);
      #1;
    end
    rd = $urandom; m_ready = 1'b1; m_rdata = rd;
    @(negedge clk);
    if (d_ready) pulses++;
    checks++;
    if ({i_ready, d_ready, d_rdata, m_addr, m_wdata} !== {2'b01, rd, 32'h2004, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL data_resp got=%b%b/%h/%h exp=01/%h/2004", i_ready, d_ready, d_rdata, m_addr, rd);
    end
    @(posedge clk);
    #1 d_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    if (d_ready) pulses++;
    checks++;
    if (pulses != 1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL data_single_pulse pulses=%0d m_valid=%b exp=1/0", pulses, m_valid);
    end
  endtask

  task automatic test_tie();
    do_reset();
    i_valid = 1'b1; i_addr = 32'h40;
    d_valid = 1'b1; d_addr = 32'h3000; d_wdata = 32'h12345678; d_wstrb = 4'h3;
    @(posedge clk);
    #1 checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 32'h3000, 32'h12345678, 4'h3}) begin
      failures++;
      $display("FAIL tie_first got=%b/%h/%h/%h exp=1/3000/12345678/3", m_valid, m_addr, m_wdata, m_wstrb);
    end
    m_ready = 1'b1;
    #1 checks++;
    if ({i_ready, d_ready} !== 2'b01) begin failures++; $display("FAIL tie_d_ready got=%b exp=01", {i_ready, d_ready}); end
    @(posedge clk);
    #1 d_valid = 1'b0; m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL tie_bubble m_valid=%b exp=0", m_valid); end
    @(posedge clk);
    #1 checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 32'h40, 32'h0, 4'h0}) begin
      failures++;
      $display("FAIL tie_second got=%b/%h/%h/%h exp=1/40/0/0", m_valid, m_addr, m_wdata, m_wstrb);
    end
    m_ready = 1'b1;
    #1 checks++;
    if ({i_ready, d_ready} !== 2'b10) begin failures++; $display("FAIL tie_i_ready got=%b exp=10", {i_ready, d_ready}); end
    @(posedge clk);
    #1 i_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_contention();
    string got = "";
    int both = 0, n = 0, cyc = 0;
    bit ir, dr;
    do_reset();
    i_valid = 1'b1; i_addr = $urandom;
    d_valid = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
    while (n < 6 && cyc < 300) begin
      m_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      ir = i_ready; dr = d_ready;
      if (ir && dr) both++;
      if (dr) begin got = {got, "D"}; n++; end
      if (ir) begin got = {got, "I"}; n++; end
      @(posedge clk);
      #1 cyc++;
      if (ir) i_addr = $urandom;
      if (dr) begin d_addr = $urandom; d_wdata = $urandom; end
    end
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
    checks++;
    if (got != "DIDIDI") begin failures++; $display("FAIL contention_order got=%s exp=DIDIDI", got); end
    checks++;
    if (both != 0) begin failures++; $display("FAIL contention_dual_ready got=%0d exp=0", both); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    d_valid = 1'b1; d_addr = $urandom | 32'h1; d_wdata = $urandom; d_wstrb = 4'hF;
    @(posedge clk);
    #1 checks++;
    if (m_valid !== 1'b1) begin failures++; $display("FAIL rstbusy_grant m_valid=%b exp=1", m_valid); end
    #2 rst = 1'b1;
    #1 checks++;
    if ({m_valid, i_ready, d_ready, m_addr, m_wdata, m_wstrb} !== '0) begin
      failures++;
      $display("FAIL rstbusy_async got=%b/%h/%h/%h exp=0", {m_valid, i_ready, d_ready}, m_addr, m_wdata, m_wstrb);
    end
    d_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      m_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({m_valid, i_ready, d_ready} !== 3'b000) begin
        failures++;
        $display("FAIL rstbusy_no_reissue got=%b exp=000", {m_valid, i_ready, d_ready});
      end
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
  endtask

  task automatic test_idle_ready();
    do_reset();
    repeat (4) begin
      m_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({m_valid, i_ready, d_ready} !== 3'b000) begin
        failures++;
        $display("FAIL idle_ready got=%b exp=000", {m_valid, i_ready, d_ready});
      end
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    bit ir = 1'b0, dr = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!i_valid || ir) begin i_valid = 1'($urandom); i_addr = $urandom; end
      if (!d_valid || dr) begin
        d_valid = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
        d_wstrb = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom);
      end
      m_ready = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({m_valid, m_addr, m_wdata, m_wstrb} !== {own != 0, ea, ew, es}) begin
        failures++;
        $display("FAIL rand_req c=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", c, m_valid, m_addr, m_wdata, m_wstrb, own != 0, ea, ew, es);
      end
      checks++;
      if ({i_ready, d_ready} !== {own == 1 && m_ready, own == 2 && m_ready}) begin
        failures++;
        $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c, i_ready, d_ready, own == 1 && m_ready, own == 2 && m_ready);
      end
      checks++;
      if ({i_rdata, d_rdata} !== {m_rdata, m_rdata}) begin
        failures++;
        $display("FAIL rand_rdata c=%0d got=%h/%h exp=%h", c, i_rdata, d_rdata, m_rdata);
      end
      ir = i_ready; dr = d_ready;
      model_edge();
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_instr();
    test_data();
    test_tie();
    test_contention();
    test_reset_busy();
    test_idle_ready();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
